muldiv_seq: RTL and testbench

MULDIV_SEQ -- requirements
Module: muldiv_seq

---
 rtl/muldiv_seq_pkg.sv | 18 +
 rtl/muldiv_step.sv | 39 +++
 rtl/muldiv_seq.sv | 128 ++++++++++++
 tb/tb_muldiv_seq.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_seq_pkg.sv
// Shared definitions for the sequential MULTU/DIVU unit: op and state
// encodings plus the fixed iteration count.
package muldiv_seq_pkg;

    localparam int ITERS = 32;
    localparam int CNT_W = 5;

    typedef enum logic {
        OP_MULTU = 1'b0,
        OP_DIVU  = 1'b1
    } op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the shared multiply/divide datapath.
// Working registers: w_hi holds the multiply accumulator or the partial
// remainder; w_lo holds the multiplier (shifting out LSB first while the
// product shifts in) or the dividend (shifting out MSB first while quotient
// bits shift in). After 32 iterations {w_hi, w_lo} is the final HI/LO.
module muldiv_step
    import muldiv_seq_pkg::*;
(
    input  logic        op_i,
    input  logic [31:0] w_hi_i,
    input  logic [31:0] w_lo_i,
    input  logic [31:0] w_b_i,
    output logic [31:0] w_hi_o,
    output logic [31:0] w_lo_o
);

    logic [32:0] sum;
    logic [32:0] shifted;
    logic [32:0] diff;

    // Shift-add for MULTU, restoring subtract for DIVU; diff[32] is the borrow.
    always_comb begin
        sum     = {1'b0, w_hi_i} + (w_lo_i[0] ? {1'b0, w_b_i} : 33'd0);
        shifted = {w_hi_i, w_lo_i[31]};
        diff    = shifted - {1'b0, w_b_i};
        w_hi_o  = sum[32:1];
        w_lo_o  = {sum[0], w_lo_i[31:1]};
        if (op_i == OP_DIVU) begin
            if (!diff[32]) begin
                w_hi_o = diff[31:0];
                w_lo_o = {w_lo_i[30:0], 1'b1};
            end else begin
                w_hi_o = shifted[31:0];
                w_lo_o = {w_lo_i[30:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/muldiv_seq.sv
// Sequential unsigned MULTU/DIVU unit with architectural HI/LO.
// Handshake: start is accepted only in IDLE and only without flush; while
// busy, start and mf_req raise stall so the front-end holds the instruction.
// Results land on HI/LO exactly 32 edges after the accept edge, and done
// pulses for the single cycle that follows.
module muldiv_seq #(
    parameter int ITERS = muldiv_seq_pkg::ITERS
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        flush,
    input  logic        mf_req,
    output logic        busy,
    output logic        stall,
    output logic        done,
    output logic        dz,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    import muldiv_seq_pkg::*;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ITERS - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;
    logic             done_q, done_d;
    logic             dz_q, dz_d;
    logic             accept;
    logic             advance;

    logic             op_q;
    logic [31:0]      b_q;
    logic [31:0]      w_hi_q, w_lo_q;
    logic [31:0]      step_hi, step_lo;

    muldiv_step u_step (
        .op_i   (op_q),
        .w_hi_i (w_hi_q),
        .w_lo_i (w_lo_q),
        .w_b_i  (b_q),
        .w_hi_o (step_hi),
        .w_lo_o (step_lo)
    );

    // Next state, counter and result registers; flush beats start and completion.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        dz_d    = dz_q;
        accept  = 1'b0;
        advance = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start && !flush) begin
                    accept  = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (flush) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    advance = 1'b1;
                    cnt_d   = cnt_q + 1'b1;
                    if (cnt_q == LAST_CNT) begin
                        state_d = ST_IDLE;
                        hi_d    = step_hi;
                        lo_d    = step_lo;
                        done_d  = 1'b1;
                        dz_d    = (op_q == OP_DIVU) && (b_q == 32'd0);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Control and architectural state, cleared immediately by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
            dz_q    <= dz_d;
        end
    end

    // Operand and working registers; their contents only matter while RUN.
    always_ff @(posedge clk) begin
        if (accept) begin
            op_q   <= op;
            b_q    <= b;
            w_hi_q <= '0;
            w_lo_q <= a;
        end else if (advance) begin
            w_hi_q <= step_hi;
            w_lo_q <= step_lo;
        end
    end

    assign busy  = (state_q == ST_RUN);
    assign stall = busy & (mf_req | start);
    assign done  = done_q;
    assign dz    = dz_q;
    assign hi    = hi_q;
    assign lo    = lo_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq: stimulus pushes expected {hi, lo, dz} into
// a queue, a monitor pops and compares on every done pulse.
module tb_muldiv_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        op = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        flush = 1'b0;
  logic        mf_req = 1'b0;
  logic        busy, stall, done, dz;
  logic [31:0] hi, lo;

  logic [64:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  muldiv_seq #(.ITERS(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .flush(flush), .mf_req(mf_req), .busy(busy), .stall(stall),
    .done(done), .dz(dz), .hi(hi), .lo(lo)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  // scoreboard monitor
  initial begin
    logic [64:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && done) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_done: hi=%h lo=%h dz=%b with no result expected", hi, lo, dz);
        end else begin
          e = exp_q.pop_front();
          if ({hi, lo, dz} !== e) begin
            errors++;
            $display("FAIL result: got hi=%h lo=%h dz=%b, expected hi=%h lo=%h dz=%b",
                     hi, lo, dz, e[64:33], e[32:1], e[0]);
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  // driver: wait for IDLE, present one start for one edge (the accept edge)
  task automatic issue(input logic o, input logic [31:0] aa, input logic [31:0] bb,
                       input logic push, input logic [31:0] eh, input logic [31:0] el,
                       input logic ed);
    int guard = 0;
    while (busy && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    check("issue_idle_wait", {31'd0, busy}, 32'd0);
    op = o; a = aa; b = bb; start = 1'b1;
    if (push) exp_q.push_back({eh, el, ed});
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // wait for done after an accept edge, measuring busy/stall occupancy
  task automatic wait_done(output int cyc, output int busy_cnt, output int stall_cnt,
                           output logic stall_at_done);
    cyc = 0; busy_cnt = 0; stall_cnt = 0; stall_at_done = 1'b0;
    while (cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (busy) busy_cnt++;
      if (stall) stall_cnt++;
      if (done) begin
        stall_at_done = stall;
        break;
      end
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL done_timeout: no done within %0d cycles", cyc);
    end
  endtask

  initial begin
    int cyc, bc, sc;
    logic sd;

    // reset state
    #12;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_stall", {31'd0, stall}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_dz", {31'd0, dz}, 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // MULTU max*max: latency 32 edges, done is a single-cycle pulse
    issue(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFE, 32'h00000001, 1'b0);
    wait_done(cyc, bc, sc, sd);
    check("mul_latency", cyc, 32'd33);
    @(negedge clk);
    check("mul_done_pulse", {31'd0, done}, 32'd0);

    // DIVU 100/7, busy for exactly 32 cycles
    issue(1'b1, 32'd100, 32'd7, 1'b1, 32'd2, 32'd14, 1'b0);
    wait_done(cyc, bc, sc, sd);
    check("div_busy_cycles", bc, 32'd32);

    // divide by zero, then MULTU clears dz
    issue(1'b1, 32'h12345678, 32'd0, 1'b1, 32'h12345678, 32'hFFFFFFFF, 1'b1);
    wait_done(cyc, bc, sc, sd);
    issue(1'b0, 32'd3, 32'd5, 1'b1, 32'd0, 32'd15, 1'b0);
    wait_done(cyc, bc, sc, sd);

    // further directed vectors
    issue(1'b0, 32'h00010000, 32'h00010000, 1'b1, 32'd1, 32'd0, 1'b0);
    wait_done(cyc, bc, sc, sd);
    issue(1'b1, 32'hFFFFFFFF, 32'h10, 1'b1, 32'hF, 32'h0FFFFFFF, 1'b0);
    wait_done(cyc, bc, sc, sd);

    // mf_req during RUN: stall every busy cycle, released on the done cycle
    issue(1'b1, 32'd1000, 32'd10, 1'b1, 32'd0, 32'd100, 1'b0);
    mf_req = 1'b1;
    wait_done(cyc, bc, sc, sd);
    check("mf_stall_cycles", sc, 32'd32);
    check("mf_stall_at_done", {31'd0, sd}, 32'd0);
    mf_req = 1'b0;

    // start held while busy is ignored (stall), then accepted on the done cycle
    issue(1'b0, 32'd7, 32'd6, 1'b1, 32'd0, 32'd42, 1'b0);
    op = 1'b1; a = 32'd50; b = 32'd3; start = 1'b1;
    exp_q.push_back({32'd2, 32'd16, 1'b0});
    wait_done(cyc, bc, sc, sd);
    check("start_stall_cycles", sc, 32'd32);
    @(posedge clk); #1;
    start = 1'b0;
    check("back_to_back_busy", {31'd0, busy}, 32'd1);
    wait_done(cyc, bc, sc, sd);

    // load hi/lo = 5/9, then flush a MULTU 2*3 at cnt=31
    issue(1'b1, 32'd68, 32'd7, 1'b1, 32'd5, 32'd9, 1'b0);
    wait_done(cyc, bc, sc, sd);
    issue(1'b0, 32'd2, 32'd3, 1'b0, 32'd0, 32'd0, 1'b0);
    repeat (31) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_busy", {31'd0, busy}, 32'd0);
    check("flush_done", {31'd0, done}, 32'd0);
    check("flush_hi", hi, 32'd5);
    check("flush_lo", lo, 32'd9);
    repeat (3) @(posedge clk);
    #1;

    // flush beats start in IDLE
    start = 1'b1; flush = 1'b1; op = 1'b0; a = 32'd9; b = 32'd9;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    check("flush_start_busy", {31'd0, busy}, 32'd0);

    // asynchronous reset at cnt=10 aborts the operation
    issue(1'b0, 32'h1234, 32'h5678, 1'b0, 32'd0, 32'd0, 1'b0);
    mf_req = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_stall", {31'd0, stall}, 32'd0);
    check("arst_done", {31'd0, done}, 32'd0);
    check("arst_dz", {31'd0, dz}, 32'd0);
    check("arst_hi", hi, 32'd0);
    check("arst_lo", lo, 32'd0);
    mf_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (25) @(posedge clk);
    #1;
    check("post_rst_no_done", {31'd0, done}, 32'd0);
    issue(1'b1, 32'd1000, 32'd3, 1'b1, 32'd1, 32'd333, 1'b0);
    wait_done(cyc, bc, sc, sd);
    repeat (3) @(posedge clk);
    #1;

    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
